// File: rtl/vedic_pkg.sv
// Shared types and helpers for the Vedic multiplier pipeline.
package vedic_pkg;

  // Half-operand width used by the Urdhva split.
  function automatic int unsigned half_w(input int unsigned width);
    return width / 2;
  endfunction

  // Valid bits travelling alongside the three pipeline stages.
  typedef struct packed {
    logic s1;
    logic s2;
    logic s3;
  } stage_valid_t;

endpackage

// File: rtl/cla_adder.sv
// Combinational W-bit carry-lookahead adder; carries are formed directly from
// generate/propagate terms. Result is truncated to W bits, so callers
// zero-extend operands when they need the carry out.
module cla_adder #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  logic [W-2:0] g;
  logic [W-1:0] p;
  logic [W-1:0] c;
  logic         term;
  logic         cy;

  // Carry into bit i = OR over j<i of g[j] AND all propagates between j and i.
  always_comb begin
    g    = a[W-2:0] & b[W-2:0];
    p    = a ^ b;
    c    = '0;
    term = 1'b0;
    cy   = 1'b0;
    for (int unsigned i = 1; i < W; i++) begin
      cy = 1'b0;
      for (int unsigned j = 0; j < i; j++) begin
        term = g[j];
        for (int unsigned k = j + 1; k < i; k++) begin
          term = term & p[k];
        end
        cy = cy | term;
      end
      c[i] = cy;
    end
    sum = p ^ c;
  end

endmodule

// File: rtl/vedic_mult_half.sv
// Combinational N x N unsigned Urdhva-Tiryakbhyam multiplier. Each column's
// vertical/crosswise bit products are counted, the counts are sliced into
// bit-planes, and the planes are summed with CLA adders.
module vedic_mult_half #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  localparam int unsigned PW = 2 * N;
  localparam int unsigned CW = $clog2(N + 1);

  logic [CW-1:0][PW-1:0] plane;
  logic [CW-1:0][PW-1:0] part;

  // Column k count contributes bit r of the count at weight k+r.
  always_comb begin
    plane = '0;
    for (int unsigned k = 0; k < PW - 1; k++) begin
      int unsigned cnt;
      cnt = 0;
      for (int unsigned i = 0; i < N; i++) begin
        if (k >= i && (k - i) < N) begin
          cnt = cnt + ((a[i] & b[k-i]) ? 1 : 0);
        end
      end
      for (int unsigned r = 0; r < CW; r++) begin
        if (k + r < PW) begin
          plane[r][k+r] = ((cnt >> r) & 1) != 0;
        end
      end
    end
  end

  // Every partial sum is bounded by the final product, so PW bits never overflow.
  assign part[0] = plane[0];
  for (genvar gi = 1; gi < CW; gi++) begin : g_acc
    cla_adder #(.W(PW)) u_add (
      .a   (part[gi-1]),
      .b   (plane[gi]),
      .sum (part[gi])
    );
  end

  assign p = part[CW-1];

endmodule

// File: rtl/vedic_mult_pipe.sv
// Three-stage pipelined unsigned WIDTH x WIDTH Vedic multiplier with a
// valid/ready handshake and a single global advance enable.
// Optional feature: define VEDIC_MAC_EN to add acc_clr/acc_out and a
// wrapping accumulator of transferred products.
module vedic_mult_pipe
  import vedic_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
`ifdef VEDIC_MAC_EN
  ,
  input  logic                 acc_clr,
  output logic [ACC_WIDTH-1:0] acc_out
`endif
);

  localparam int unsigned HALF = half_w(WIDTH);
  localparam int unsigned PW   = 2 * HALF;

  if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("vedic_mult_pipe: WIDTH must be even and >= 4");
  end
  if (ACC_WIDTH < 2 * WIDTH) begin : g_bad_acc
    $error("vedic_mult_pipe: ACC_WIDTH must be >= 2*WIDTH");
  end

  typedef struct packed {
    logic [PW-1:0] q0;
    logic [PW-1:0] q1;
    logic [PW-1:0] q2;
    logic [PW-1:0] q3;
  } pp_t;

  typedef struct packed {
    logic [PW-1:0] q0;
    logic [PW:0]   mid;
    logic [PW-1:0] q3;
  } red_t;

  stage_valid_t       sv_q, sv_d;
  pp_t                pp_q, pp_d, pp_c;
  red_t               rd_q, rd_d;
  logic [PW:0]        mid_c;
  logic [2*WIDTH-1:0] prod_c;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               adv;

  vedic_mult_half #(.N(HALF)) u_q0 (.a(a[HALF-1:0]),     .b(b[HALF-1:0]),     .p(pp_c.q0));
  vedic_mult_half #(.N(HALF)) u_q1 (.a(a[WIDTH-1:HALF]), .b(b[HALF-1:0]),     .p(pp_c.q1));
  vedic_mult_half #(.N(HALF)) u_q2 (.a(a[HALF-1:0]),     .b(b[WIDTH-1:HALF]), .p(pp_c.q2));
  vedic_mult_half #(.N(HALF)) u_q3 (.a(a[WIDTH-1:HALF]), .b(b[WIDTH-1:HALF]), .p(pp_c.q3));

  cla_adder #(.W(PW + 1)) u_mid (
    .a   ({1'b0, pp_q.q1}),
    .b   ({1'b0, pp_q.q2}),
    .sum (mid_c)
  );

  // q3 and q0 occupy disjoint bit ranges, so they concatenate without an add.
  cla_adder #(.W(2 * WIDTH)) u_fin (
    .a   ({rd_q.q3, rd_q.q0}),
    .b   ({{(HALF - 1){1'b0}}, rd_q.mid, {HALF{1'b0}}}),
    .sum (prod_c)
  );

  // Next-state for all stages: everything moves together when adv is high.
  always_comb begin
    adv       = !(sv_q.s3 && !out_ready);
    sv_d      = sv_q;
    pp_d      = pp_q;
    rd_d      = rd_q;
    product_d = product_q;
    if (adv) begin
      sv_d = '{s1: in_valid, s2: sv_q.s1, s3: sv_q.s2};
      pp_d = pp_c;
      rd_d = '{q0: pp_q.q0, mid: mid_c, q3: pp_q.q3};
      // Bubbles pass through but must not overwrite the last visible product.
      if (sv_q.s2) begin
        product_d = prod_c;
      end
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sv_q      <= '0;
      pp_q      <= '0;
      rd_q      <= '0;
      product_q <= '0;
    end else begin
      sv_q      <= sv_d;
      pp_q      <= pp_d;
      rd_q      <= rd_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = sv_q.s3;
  assign product   = product_q;

`ifdef VEDIC_MAC_EN
  logic [ACC_WIDTH-1:0] acc_q, acc_d;

  // Clear takes effect first, so a coincident transfer lands on zero.
  always_comb begin
    acc_d = acc_clr ? '0 : acc_q;
    if (sv_q.s3 && out_ready) begin
      acc_d = acc_d + ACC_WIDTH'(product_q);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_out = acc_q;
`endif

endmodule
